// File: rtl/signal_prescaler.sv
// Input conditioner: 2-flop sync, N-sample glitch filter, optional /2*div toggle divider, edge strobe, loss flag.
// Latency raw->signal_o is 3+FILTER_LEN cycles; free-running stream, no backpressure.
module signal_prescaler #(
   parameter int DIV_W      = 16,
   parameter int FILTER_LEN = 3,
   parameter int TIMEOUT    = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             signal_raw_i,
   input  logic             enable_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             signal_o,
   output logic             edge_stb_o,
   output logic             signal_present_o
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int LCW = $clog2(TIMEOUT + 1);
   localparam logic [FCW-1:0]   FCNT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [FCW-1:0]   FCNT_ONE  = FCW'(1);
   localparam logic [LCW-1:0]   LCNT_MAX  = LCW'(TIMEOUT);
   localparam logic [LCW-1:0]   LCNT_ONE  = LCW'(1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

   logic             s1_q, s2_q;
   logic             filt_q, filt_d;
   logic [FCW-1:0]   fcnt_q, fcnt_d;
   logic             edge_stb_q, edge_stb_d;
   logic [DIV_W-1:0] ecnt_q, ecnt_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic             sig_q, sig_d;
   logic [LCW-1:0]   lcnt_q, lcnt_d;

   // A new level must be seen FILTER_LEN consecutive cycles before filt follows it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (s2_q == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
         filt_d = s2_q;
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + FCNT_ONE;
      end
   end

   assign edge_stb_d = filt_d & ~filt_q;

   // Ratio is only re-sampled at a wrap (or while disabled) so the output never glitches.
   always_comb begin
      ecnt_d    = ecnt_q;
      div_act_d = div_act_q;
      sig_d     = sig_q;
      if (!enable_i) begin
         ecnt_d    = '0;
         sig_d     = 1'b0;
         div_act_d = div_i;
      end else if (div_act_q == '0) begin
         sig_d = filt_q;
      end else if (edge_stb_q) begin
         if (ecnt_q == div_act_q - DIV_ONE) begin
            ecnt_d    = '0;
            sig_d     = ~sig_q;
            div_act_d = div_i;
         end else begin
            ecnt_d = ecnt_q + DIV_ONE;
         end
      end
   end

   always_comb begin
      lcnt_d = lcnt_q;
      if (edge_stb_q) begin
         lcnt_d = '0;
      end else if (lcnt_q != LCNT_MAX) begin
         lcnt_d = lcnt_q + LCNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         filt_q     <= 1'b0;
         fcnt_q     <= '0;
         edge_stb_q <= 1'b0;
         ecnt_q     <= '0;
         div_act_q  <= '0;
         sig_q      <= 1'b0;
         lcnt_q     <= LCNT_MAX;
      end else begin
         s1_q       <= signal_raw_i;
         s2_q       <= s1_q;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         edge_stb_q <= edge_stb_d;
         ecnt_q     <= ecnt_d;
         div_act_q  <= div_act_d;
         sig_q      <= sig_d;
         lcnt_q     <= lcnt_d;
      end
   end

   assign signal_o         = sig_q;
   assign edge_stb_o       = edge_stb_q;
   assign signal_present_o = (lcnt_q < LCNT_MAX);

endmodule

// File: tb/tb_signal_prescaler.sv
// Directed bench for signal_prescaler: stimulus pushes expected strobe/output/presence events, a monitor pops and compares.
// Inputs change on the falling edge; cyc holds the index of the last rising edge.
module tb_signal_prescaler;

   localparam int FL = 3;
   localparam int TO = 64;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          raw = 1'b0;
   logic          en = 1'b0;
   logic [DW-1:0] div = '0;
   logic          sig, stb, pres;

   signal_prescaler #(.DIV_W(DW), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .signal_raw_i    (raw),
      .enable_i        (en),
      .div_i           (div),
      .signal_o        (sig),
      .edge_stb_o      (stb),
      .signal_present_o(pres)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit val;
   } ev_t;

   ev_t stb_q[$];
   ev_t sig_q[$];
   ev_t pres_q[$];
   ev_t me;

   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   logic sig_prev = 1'b0;
   logic pres_prev = 1'b0;
   int   mode = 0;
   bit   exp_present = 1'b0;
   int   last_stb = 0;

   function automatic void cmp(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Monitor: every strobe, signal_o change and presence change must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stb === 1'b1) begin
            if (stb_q.size() == 0) cmp("stb_unexpected", cyc, -1);
            else begin
               me = stb_q.pop_front();
               cmp("stb_cycle", cyc, me.cyc);
            end
         end
         if (sig !== sig_prev) begin
            if (sig_q.size() == 0) cmp("sig_unexpected", cyc, -1);
            else begin
               me = sig_q.pop_front();
               cmp("sig_cycle", cyc, me.cyc);
               cmp("sig_value", int'(sig), int'(me.val));
            end
         end
         if (pres !== pres_prev) begin
            if (pres_q.size() == 0) cmp("pres_unexpected", cyc, -1);
            else begin
               me = pres_q.pop_front();
               cmp("pres_cycle", cyc, me.cyc);
               cmp("pres_value", int'(pres), int'(me.val));
            end
         end
      end
      sig_prev  <= sig;
      pres_prev <= pres;
   end

   task automatic push_sig(int c, bit v);
      sig_q.push_back('{c, v});
   endtask

   task automatic push_stb(int s);
      stb_q.push_back('{s, 1'b1});
      if (!exp_present) begin
         pres_q.push_back('{s + 1, 1'b1});
         exp_present = 1'b1;
      end
      last_stb = s;
   endtask

   // Raw rises at this falling edge: strobe seen 5 cycles later, bypass output 6 cycles later.
   task automatic pulse(int hi, int lo, bit acc, bit dis_at_stb);
      int c0;
      c0 = cyc;
      if (acc) begin
         push_stb(c0 + 5);
         if (mode == 1) begin
            push_sig(c0 + 6, 1'b1);
            push_sig(c0 + hi + 6, 1'b0);
         end
      end
      for (int i = 0; i < hi + lo; i++) begin
         raw = (i < hi);
         if (dis_at_stb && i == 5) en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic go_quiet();
      if (exp_present) begin
         pres_q.push_back('{last_stb + TO + 1, 1'b0});
         exp_present = 1'b0;
      end
      while (cyc < last_stb + TO + 6) @(negedge clk);
   endtask

   task automatic set_mode(bit e, int d, int m);
      en  = 1'b0;
      div = DW'(d);
      repeat (2) @(negedge clk);
      en   = e;
      mode = m;
      @(negedge clk);
   endtask

   initial begin
      // Reset held while the input toggles with an 8-cycle period.
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         raw = ((i % 8) < 4);
         @(negedge clk);
         cmp("rst_outputs", int'({sig, stb, pres}), 0);
      end
      raw = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      cmp("post_rst_sig", int'(sig), 0);
      cmp("post_rst_stb", int'(stb), 0);
      cmp("post_rst_pres", int'(pres), 0);
      mon_en = 1'b1;

      // Glitch rejection in bypass.
      set_mode(1'b1, 0, 1);
      pulse(2, 10, 1'b0, 1'b0);
      pulse(3, 10, 1'b1, 1'b0);

      // Bypass, 80 ns input.
      for (int k = 0; k < 6; k++) pulse(4, 4, 1'b1, 1'b0);
      go_quiet();

      // Divide by 4: toggles after strobes 4 and 8.
      set_mode(1'b1, 4, 2);
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) push_sig(cyc + 6, 1'b1);
         if (k == 8) push_sig(cyc + 6, 1'b0);
         pulse(4, 4, 1'b1, 1'b0);
      end
      go_quiet();

      // Ratio 4 -> 2 after strobe 5: applies from the wrap at strobe 8.
      set_mode(1'b1, 4, 2);
      for (int k = 1; k <= 12; k++) begin
         if (k == 4 || k == 10) push_sig(cyc + 6, 1'b1);
         if (k == 8 || k == 12) push_sig(cyc + 6, 1'b0);
         pulse(4, 4, 1'b1, 1'b0);
         if (k == 5) div = DW'(2);
      end
      go_quiet();

      // Disable in the wrap cycle of strobe 6: no toggle, counter restarts.
      set_mode(1'b1, 2, 2);
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) push_sig(cyc + 6, 1'b1);
         if (k == 4) push_sig(cyc + 6, 1'b0);
         pulse(4, 4, 1'b1, (k == 6));
      end
      mode = 0;
      repeat (3) @(negedge clk);
      set_mode(1'b1, 2, 2);
      for (int k = 1; k <= 4; k++) begin
         if (k == 2) push_sig(cyc + 6, 1'b1);
         if (k == 4) push_sig(cyc + 6, 1'b0);
         pulse(4, 4, 1'b1, 1'b0);
      end

      // Divide by 1 toggles on every strobe.
      set_mode(1'b1, 1, 2);
      for (int k = 1; k <= 3; k++) begin
         push_sig(cyc + 6, (k % 2) == 1);
         pulse(4, 4, 1'b1, 1'b0);
      end

      // Asynchronous reset mid-run with signal_o and presence high.
      cmp("pre_rst_sig", int'(sig), 1);
      cmp("pre_rst_pres", int'(pres), 1);
      cmp("pre_rst_pending", stb_q.size() + sig_q.size() + pres_q.size(), 0);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 cmp("midrst_outputs", int'({sig, stb, pres}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_present = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmp("after_midrst_outputs", int'({sig, stb, pres}), 0);
      end

      cmp("leftover_expected", stb_q.size() + sig_q.size() + pres_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
